fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries (power of two, >=2).
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port redirect_valid_i  input  1  jump/branch redirect strobe.
REQ-007 SHALL have port redirect_pc_i  input  XLEN  redirect target.
REQ-008 SHALL have port imem_req_valid_o  output  1  fetch request valid.
REQ-009 SHALL have port imem_req_ready_i  input  1  memory accepts request.
REQ-010 SHALL have port imem_req_addr_o  output  XLEN  fetch address.
REQ-011 SHALL have port imem_rsp_valid_i  input  1  response valid, one per accepted request, in order, >=1 cycle after acceptance.
REQ-012 SHALL have port imem_rsp_data_i  input  32  fetched instruction.
REQ-013 SHALL have port inst_valid_o  output  1  buffer head valid.
REQ-014 SHALL have port inst_ready_i  input  1  decoder consumes head.
REQ-015 SHALL have port inst_o  output  32  head instruction.
REQ-016 SHALL have port inst_pc_o  output  XLEN  PC of head instruction.

Function
REQ-017 SHALL keep at most one outstanding request; states REQ (req_valid high), WAIT (await rsp), DROP (await rsp to discard).
REQ-018 SHALL, in REQ, assert imem_req_valid_o only when buffer count + reserved slots < DEPTH; otherwise hold in REQ with valid low.
REQ-019 SHALL, on req_valid && req_ready, go REQ->WAIT, record request PC, and set fetch PC = fetch PC + 4 modulo 2^XLEN.
REQ-020 SHALL, in WAIT on rsp_valid, write {request PC, rsp_data} into buffer tail and return to REQ; a new request may issue the following cycle.
REQ-021 SHALL present buffer head combinationally from registered storage: inst_valid_o = !empty; head pops on inst_valid_o && inst_ready_i.
REQ-022 SHALL give latency rsp_valid in cycle N -> inst_valid_o high in cycle N+1 when buffer was empty.
REQ-023 SHALL support simultaneous push and pop in one cycle, count unchanged, including at count == DEPTH-1 and count == 1.
REQ-024 SHALL never push when full; slot reservation in REQ-018 guarantees this; pop when empty is ignored.
REQ-025 SHALL, on redirect_valid_i, flush buffer (count=0, inst_valid_o low next cycle), set fetch PC = {redirect_pc_i[XLEN-1:2], 2'b00}; redirect overrides same-cycle pop and push.
REQ-026 SHALL, on redirect in WAIT without same-cycle rsp_valid, go to DROP; in DROP, on rsp_valid discard data and go to REQ.
REQ-027 SHALL, on redirect in WAIT with same-cycle rsp_valid, discard the response and go to REQ.
REQ-028 SHALL, on redirect in REQ with same-cycle handshake, go to DROP; without handshake stay in REQ, imem_req_addr_o showing new PC next cycle (only case address changes while valid is high).
REQ-029 SHALL ignore further redirects in DROP except updating fetch PC (last redirect wins).
REQ-030 SHALL keep pointers DEPTH-wrapped (log2(DEPTH) bits) with separate count of log2(DEPTH)+1 bits.

Reset
REQ-031 SHALL, while rst_i high at a clock edge, set state=REQ, fetch PC=RESET_PC, count=0, pointers=0, regardless of outstanding requests.
REQ-032 SHALL drive imem_req_valid_o=0 and inst_valid_o=0 during the reset cycle; inst_o and inst_pc_o values then don't-care.
REQ-033 SHALL assert imem_req_valid_o with addr=RESET_PC in the first cycle after rst_i falls; a response to a pre-reset request is outside spec.

Verification
REQ-034 SHALL cover reset release, ready=1, 1-cycle rsp latency, inst_ready=1 -> addrs 0x80000000, 0x80000004, 0x80000008 issued; inst_pc_o matches each in order.
REQ-035 SHALL cover inst_ready=0 with DEPTH=4 -> exactly 4 requests issued, then req_valid low; one pop -> exactly one further request.
REQ-036 SHALL cover redirect to 0x80000100 in WAIT -> in-flight rsp discarded, buffer empty, next request addr 0x80000100.
REQ-037 SHALL cover redirect to 0x80000203 -> next request addr 0x80000200.
REQ-038 SHALL cover fetch PC 0xFFFFFFFC accepted -> next request addr 0x00000000.
REQ-039 SHALL cover rst_i asserted in WAIT with 2 buffered entries -> next cycle inst_valid_o=0, then request to 0x80000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory request engine feeding a
// small instruction buffer, with redirect flush and in-flight response drop.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] req_pc_reg, req_pc_next;
  logic [AW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic            req_fire, push, pop;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Nothing is outstanding in REQ, so the only slot a new request must
  // reserve is its own; this is what keeps pushes away from a full buffer.
  assign imem_req_valid_o = !rst_i && (state_reg == S_REQ) && (count_reg < DEPTH_C);
  assign imem_req_addr_o  = fetch_pc_reg;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign inst_valid_o = !rst_i && (count_reg != '0);
  assign inst_o       = inst_mem[head_reg];
  assign inst_pc_o    = pc_mem[head_reg];

  assign push = (state_reg == S_WAIT) && imem_rsp_valid_i && !redirect_valid_i;
  assign pop  = inst_valid_o && inst_ready_i && !redirect_valid_i;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    case (state_reg)
      S_REQ: begin
        if (req_fire) begin
          req_pc_next   = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + XLEN'(4);
          state_next    = redirect_valid_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          state_next = S_REQ;
        end else if (redirect_valid_i) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid_i) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
    // A redirect always wins the fetch PC, in every state.
    if (redirect_valid_i) begin
      fetch_pc_next = {redirect_pc_i[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= S_REQ;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      if (redirect_valid_i) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + AW'(1);
        if (pop)  head_reg <= head_reg + AW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem[tail_reg] <= imem_rsp_data_i;
      pc_mem[tail_reg]   <= req_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle table for the main flow and redirects, plus
// hand-written sequences with a one-cycle-latency memory for backpressure and reset.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic rdv; logic [31:0] rdpc; logic rdy; logic rspv; logic [31:0] rspd; logic ird;
    logic rv;  logic [31:0] ra;   logic iv;  logic [31:0] ipc; logic [31:0] ins;
  } vec_t;

  localparam int NV = 19;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  vec_t tbl [NV];

  logic        pending;
  logic [31:0] pend_addr;
  int          nreq;
  logic [31:0] req_addrs [32];

  function automatic vec_t mk(input logic rdv, input logic [31:0] rdpc, input logic rdy,
                              input logic rspv, input logic [31:0] rspd, input logic ird,
                              input logic rv, input logic [31:0] ra, input logic iv,
                              input logic [31:0] ipc, input logic [31:0] ins);
    vec_t v;
    v.rdv = rdv; v.rdpc = rdpc; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.ird = ird;
    v.rv = rv; v.ra = ra; v.iv = iv; v.ipc = ipc; v.ins = ins;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    inst_ready_i = 1'b0; pending = 1'b0; nreq = 0;
    @(posedge clk_i);
  endtask

  // Memory model: accepts every request, answers exactly one cycle later.
  task automatic run_mem(input int n, input logic ird);
    logic hs;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      rst_i = 1'b0; redirect_valid_i = 1'b0; imem_req_ready_i = 1'b1;
      inst_ready_i = ird; imem_rsp_valid_i = pending; imem_rsp_data_i = pend_addr ^ KEY;
      #1;
      hs = imem_req_valid_o;
      if (hs) begin
        if (nreq < 32) req_addrs[nreq] = imem_req_addr_o;
        nreq++;
        $display("req %0d addr=%h", nreq, imem_req_addr_o);
      end
      @(posedge clk_i);
      pending = hs;
      if (hs) pend_addr = imem_req_addr_o;
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 1, 0, 0, 1,                   1, 32'h8000_0000, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 32'h1111_1111, 1,       0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 1,                   1, 32'h8000_0004, 1, 32'h8000_0000, 32'h1111_1111);
    tbl[3]  = mk(0, 0, 0, 1, 32'h2222_2222, 1,       0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0,                   1, 32'h8000_0008, 1, 32'h8000_0004, 32'h2222_2222);
    tbl[5]  = mk(0, 0, 0, 1, 32'h3333_3333, 1,       0, 0, 1, 32'h8000_0004, 32'h2222_2222);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0,                   1, 32'h8000_000C, 1, 32'h8000_0008, 32'h3333_3333);
    tbl[7]  = mk(1, 32'h8000_0100, 0, 0, 0, 0,       0, 0, 1, 32'h8000_0008, 32'h3333_3333);
    tbl[8]  = mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0,       0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 32'h8000_0203, 0, 0, 0, 0,       1, 32'h8000_0100, 0, 0, 0);
    tbl[10] = mk(1, 32'hFFFF_FFFC, 1, 0, 0, 0,       1, 32'h8000_0200, 0, 0, 0);
    tbl[11] = mk(1, 32'h1234_5678, 0, 0, 0, 0,       0, 0, 0, 0, 0);
    tbl[12] = mk(1, 32'hFFFF_FFFE, 0, 0, 0, 0,       0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 32'h5555_5555, 0,       0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 1, 0, 0, 0,                   1, 32'hFFFF_FFFC, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 32'h6666_6666, 0,       0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 1, 0, 0, 0,                   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h6666_6666);
    tbl[17] = mk(1, 32'h8000_0100, 0, 1, 32'h7777_7777, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h6666_6666);
    tbl[18] = mk(0, 0, 0, 0, 0, 0,                   1, 32'h8000_0100, 0, 0, 0);

    pend_addr = '0;
    reset_dut();
    @(negedge clk_i); #1;
    check("reset req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    check("reset inst_valid", {31'd0, inst_valid_o}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      rst_i = 1'b0;
      redirect_valid_i = tbl[i].rdv; redirect_pc_i = tbl[i].rdpc;
      imem_req_ready_i = tbl[i].rdy; imem_rsp_valid_i = tbl[i].rspv;
      imem_rsp_data_i = tbl[i].rspd; inst_ready_i = tbl[i].ird;
      #1;
      $display("row %0d req_valid=%b addr=%h inst_valid=%b pc=%h inst=%h",
               i, imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_pc_o, inst_o);
      check($sformatf("row%0d req_valid", i), {31'd0, imem_req_valid_o}, {31'd0, tbl[i].rv});
      if (tbl[i].rv) check($sformatf("row%0d req_addr", i), imem_req_addr_o, tbl[i].ra);
      check($sformatf("row%0d inst_valid", i), {31'd0, inst_valid_o}, {31'd0, tbl[i].iv});
      if (tbl[i].iv) begin
        check($sformatf("row%0d inst_pc", i), inst_pc_o, tbl[i].ipc);
        check($sformatf("row%0d inst", i), inst_o, tbl[i].ins);
      end
    end

    // Backpressure: decoder stalled, buffer fills after exactly DEPTH requests.
    reset_dut();
    run_mem(14, 1'b0);
    check("full nreq", 32'(nreq), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("full addr%0d", k), req_addrs[k], 32'h8000_0000 + 32'(4 * k));
    @(negedge clk_i);
    imem_rsp_valid_i = 1'b0; inst_ready_i = 1'b0; #1;
    check("full req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    check("full head pc", inst_pc_o, 32'h8000_0000);
    check("full head inst", inst_o, 32'h8000_0000 ^ KEY);
    run_mem(1, 1'b1);
    run_mem(8, 1'b0);
    check("one pop nreq", 32'(nreq), 32'd5);
    check("one pop addr", req_addrs[4], 32'h8000_0010);
    check("one pop head pc", inst_pc_o, 32'h8000_0004);

    // Push and pop together at count == DEPTH-1 keeps count at DEPTH-1.
    run_mem(1, 1'b1);
    run_mem(1, 1'b0);
    run_mem(1, 1'b1);
    @(negedge clk_i);
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; inst_ready_i = 1'b0; #1;
    check("d-1 req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    check("d-1 req_addr", imem_req_addr_o, 32'h8000_0018);
    check("d-1 head pc", inst_pc_o, 32'h8000_000C);

    // Reset while waiting with two buffered entries.
    reset_dut();
    run_mem(5, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1; imem_rsp_valid_i = 1'b0; imem_req_ready_i = 1'b0; pending = 1'b0; #1;
    check("rst in wait req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    check("rst in wait inst_valid", {31'd0, inst_valid_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; #1;
    check("post rst inst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("post rst req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    check("post rst req_addr", imem_req_addr_o, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
